// File: rtl/apb4_timer_mc.sv
`default_nettype none
// ============================================================================
// Module      : apb4_timer_mc
// Description : Multi-channel APB4 timer. CH_NUM independent channels, each
//               with a clock-enable prescaler, a read/write counter, up/down
//               direction, periodic or one-pulse mode and an overflow
//               interrupt. Zero-wait-state APB4 slave; everything runs on
//               clk_i.
// Ports       : clk_i      block clock (APB PCLK)
//               rst_i      asynchronous active-high reset
//               paddr_i    APB byte address (bits [1:0] ignored)
//               psel_i     APB select
//               penable_i  APB enable
//               pwrite_i   APB write
//               pwdata_i   APB write data
//               prdata_o   APB read data (combinational, 0 outside reads)
//               pready_o   APB ready, always 1
//               pslverr_o  APB error on unmapped access phase
//               irq_o      per-channel interrupt = OVIE & OVIF
// Register map (channel i at i*0x10):
//               +0x0 CTRL {OPM,DIR,EN,OVIE,OVIF}  +0x4 PSCR
//               +0x8 CNT                          +0xC CMP
// Revision    : 1.0 - initial release
// ============================================================================
module apb4_timer_mc #(
    parameter int CH_NUM = 4,
    parameter int CNT_W  = 32,
    parameter int PSC_W  = 20,
    parameter int ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [31:0]       pwdata_i,
    output logic [31:0]       prdata_o,
    output logic              pready_o,
    output logic              pslverr_o,
    output logic [CH_NUM-1:0] irq_o
);

    localparam int          c_WORD_W    = ADDR_W - 2;
    localparam int unsigned c_MAP_WORDS = CH_NUM * 4;

    // ------------------------------------------------------------------
    // APB decode
    // ------------------------------------------------------------------
    logic [c_WORD_W-1:0] w_word;
    logic [31:0]         w_ch_idx;
    logic [1:0]          w_reg;
    logic                w_access;
    logic                w_mapped;
    logic                w_wr;
    logic                w_rd;
    logic                w_unused_addr;
    logic [31:0]         w_rdata_ch [CH_NUM];

    assign w_word        = paddr_i[ADDR_W-1:2];
    assign w_unused_addr = ^paddr_i[1:0];
    assign w_access      = psel_i & penable_i;
    assign w_mapped      = (32'(w_word) < c_MAP_WORDS);
    assign w_ch_idx      = 32'(w_word) >> 2;
    assign w_reg         = w_word[1:0];
    assign w_wr          = w_access & pwrite_i & w_mapped;
    assign w_rd          = w_access & ~pwrite_i & w_mapped;

    assign pready_o  = 1'b1;
    assign pslverr_o = w_access & ~w_mapped;

    always_comb begin
        prdata_o = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (w_rd && (w_ch_idx == 32'(i))) begin
                prdata_o = w_rdata_ch[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
        logic             r_ovif;
        logic             r_ovie;
        logic             r_en;
        logic             r_dir;
        logic             r_opm;
        logic [PSC_W-1:0] r_pscr;
        logic [PSC_W-1:0] r_psc_cnt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_cmp;

        logic             w_sel;
        logic             w_ctrl_wr;
        logic             w_pscr_wr;
        logic             w_cnt_wr;
        logic             w_cmp_wr;
        logic             w_tick;
        logic             w_event;
        logic             w_en_nxt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic [31:0]      w_rd_val;

        assign w_sel     = w_wr & (w_ch_idx == 32'(gi));
        assign w_ctrl_wr = w_sel & (w_reg == 2'd0);
        assign w_pscr_wr = w_sel & (w_reg == 2'd1);
        assign w_cnt_wr  = w_sel & (w_reg == 2'd2);
        assign w_cmp_wr  = w_sel & (w_reg == 2'd3);

        assign w_tick = r_en & (r_psc_cnt == r_pscr);

        // A CNT write overrides the tick entirely, so no reload and no
        // event can happen in that cycle.
        always_comb begin
            w_cnt_nxt = r_cnt;
            w_event   = 1'b0;
            if (w_cnt_wr) begin
                w_cnt_nxt = pwdata_i[CNT_W-1:0];
            end else if (w_tick) begin
                if (!r_dir) begin
                    if (r_cnt == r_cmp) begin
                        w_cnt_nxt = '0;
                        w_event   = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    if (r_cnt == '0) begin
                        w_cnt_nxt = r_cmp;
                        w_event   = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
            end
        end

        // One-pulse event beats a concurrent EN write.
        assign w_en_nxt = (w_event & r_opm) ? 1'b0 :
                          (w_ctrl_wr ? pwdata_i[2] : r_en);

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_ovif    <= 1'b0;
                r_ovie    <= 1'b0;
                r_en      <= 1'b0;
                r_dir     <= 1'b0;
                r_opm     <= 1'b0;
                r_pscr    <= '0;
                r_psc_cnt <= '0;
                r_cnt     <= '0;
                r_cmp     <= '0;
            end else begin
                r_cnt <= w_cnt_nxt;
                r_en  <= w_en_nxt;

                // Hardware set wins over a software clear in the same cycle.
                if (w_event) begin
                    r_ovif <= 1'b1;
                end else if (w_ctrl_wr && !pwdata_i[0]) begin
                    r_ovif <= 1'b0;
                end

                if (w_ctrl_wr) begin
                    r_ovie <= pwdata_i[1];
                    r_dir  <= pwdata_i[3];
                    r_opm  <= pwdata_i[4];
                end
                if (w_pscr_wr) begin
                    r_pscr <= pwdata_i[PSC_W-1:0];
                end
                if (w_cmp_wr) begin
                    r_cmp <= pwdata_i[CNT_W-1:0];
                end

                // Prescaler restarts on PSCR write, while disabled, when
                // being disabled, and after each tick.
                if (w_pscr_wr || !r_en || !w_en_nxt || w_tick) begin
                    r_psc_cnt <= '0;
                end else begin
                    r_psc_cnt <= r_psc_cnt + PSC_W'(1);
                end
            end
        end

        always_comb begin
            w_rd_val = '0;
            case (w_reg)
                2'd0:    w_rd_val = {27'd0, r_opm, r_dir, r_en, r_ovie, r_ovif};
                2'd1:    w_rd_val = 32'(r_pscr);
                2'd2:    w_rd_val = 32'(r_cnt);
                default: w_rd_val = 32'(r_cmp);
            endcase
        end

        assign w_rdata_ch[gi] = w_rd_val;
        assign irq_o[gi]      = r_ovie & r_ovif;
    end

endmodule
`default_nettype wire

// File: tb/tb_apb4_timer_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb4_timer_mc
// Description : Self-checking bench for apb4_timer_mc. A channel-level model
//               tracks the register state; a compare process checks every
//               output against it each cycle. Directed sequences pin the
//               model with literal expectations, followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb4_timer_mc;

    localparam int CH_NUM = 4;
    localparam int CNT_W  = 32;
    localparam int PSC_W  = 20;
    localparam int ADDR_W = 12;

    localparam logic [31:0] c_CMASK = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [31:0] c_PMASK = 32'((64'd1 << PSC_W) - 64'd1);

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;
    logic [CH_NUM-1:0] irq;

    int checks   = 0;
    int failures = 0;

    apb4_timer_mc #(
        .CH_NUM (CH_NUM),
        .CNT_W  (CNT_W),
        .PSC_W  (PSC_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .paddr_i   (paddr),
        .psel_i    (psel),
        .penable_i (penable),
        .pwrite_i  (pwrite),
        .pwdata_i  (pwdata),
        .prdata_o  (prdata),
        .pready_o  (pready),
        .pslverr_o (pslverr),
        .irq_o     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Model: per-channel architectural state
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        ovif;
        logic        ovie;
        logic        en;
        logic        dir;
        logic        opm;
        logic [31:0] pscr;
        logic [31:0] phase;   // clocks elapsed in the current prescale period
        logic [31:0] cnt;
        logic [31:0] cmp;
    } chan_t;

    chan_t m [CH_NUM];

    function automatic chan_t ch_next(input chan_t s, input int c);
        chan_t n;
        int    word;
        int    r;
        logic  wr;
        logic  tick;
        logic  ev;
        n    = s;
        ev   = 1'b0;
        word = int'(paddr) / 4;
        r    = word % 4;
        wr   = psel && penable && pwrite && (word < CH_NUM * 4) && (word / 4 == c);
        tick = s.en && (s.phase == s.pscr);

        if (wr && r == 2) begin
            n.cnt = pwdata & c_CMASK;
        end else if (tick && !s.dir) begin
            if (s.cnt == s.cmp) begin n.cnt = 0; ev = 1'b1; end
            else n.cnt = (s.cnt + 1) & c_CMASK;
        end else if (tick && s.dir) begin
            if (s.cnt == 0) begin n.cnt = s.cmp; ev = 1'b1; end
            else n.cnt = s.cnt - 1;
        end

        if (wr && r == 0) begin
            n.ovie = pwdata[1];
            n.en   = pwdata[2];
            n.dir  = pwdata[3];
            n.opm  = pwdata[4];
            if (!pwdata[0]) n.ovif = 1'b0;
        end
        if (ev) begin
            n.ovif = 1'b1;
            if (s.opm) n.en = 1'b0;
        end
        if (wr && r == 1) n.pscr = pwdata & c_PMASK;
        if (wr && r == 3) n.cmp  = pwdata & c_CMASK;

        if ((wr && r == 1) || !s.en || !n.en || tick) n.phase = 0;
        else n.phase = s.phase + 1;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CH_NUM; c++) m[c] <= '0;
        end else begin
            for (int c = 0; c < CH_NUM; c++) m[c] <= ch_next(m[c], c);
        end
    end

    function automatic logic [31:0] exp_rdata();
        int word;
        word = int'(paddr) / 4;
        if (!(psel && penable && !pwrite) || word >= CH_NUM * 4) return 32'd0;
        case (word % 4)
            0:       return {27'd0, m[word/4].opm, m[word/4].dir, m[word/4].en,
                             m[word/4].ovie, m[word/4].ovif};
            1:       return m[word/4].pscr;
            2:       return m[word/4].cnt;
            default: return m[word/4].cmp;
        endcase
    endfunction

    function automatic logic [31:0] exp_slverr();
        return 32'(psel && penable && (int'(paddr) / 4 >= CH_NUM * 4));
    endfunction

    function automatic logic [31:0] exp_irq();
        logic [31:0] v;
        v = 0;
        for (int c = 0; c < CH_NUM; c++) v[c] = m[c].ovie & m[c].ovif;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle compare against the model
    always @(negedge clk) begin
        #2;
        chk("pready",  32'(pready),  32'd1);
        chk("pslverr", 32'(pslverr), exp_slverr());
        chk("prdata",  prdata,       exp_rdata());
        chk("irq",     32'(irq),     exp_irq());
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive(input logic s, input logic e, input logic w,
                         input logic [ADDR_W-1:0] a, input logic [31:0] d);
        @(negedge clk);
        psel = s; penable = e; pwrite = w; paddr = a; pwdata = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        drive(1'b1, 1'b0, 1'b1, a, d);
        drive(1'b1, 1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input string nm);
        drive(1'b1, 1'b0, 1'b0, a, '0);
        drive(1'b1, 1'b1, 1'b0, a, '0);
        #2 chk(nm, prdata, exp);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] ch1_seq [5];
        ch1_seq = '{32'd2, 32'd1, 32'd0, 32'd5, 32'd4};

        rst = 1'b1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset values
        rd(12'h000, 32'd0, "rst_ctrl0");
        rd(12'h004, 32'd0, "rst_pscr0");
        rd(12'h008, 32'd0, "rst_cnt0");
        rd(12'h03C, 32'd0, "rst_cmp3");

        // Ch0 up periodic: CNT 0,1,2,3,0,1
        wr(12'h004, 32'd0);
        wr(12'h00C, 32'd3);
        wr(12'h000, 32'h6);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, 12'h008, '0);
            #2 chk("ch0_up_cnt", prdata, 32'(i % 4));
        end
        rd(12'h000, 32'h7, "ch0_ovif_set");
        chk("ch0_irq_set", 32'(irq[0]), 32'd1);
        wr(12'h000, 32'h6);
        rd(12'h000, 32'h6, "ch0_ovif_clr");
        chk("ch0_irq_clr", 32'(irq[0]), 32'd0);
        wr(12'h000, 32'h0);

        // Collision: OVIF clear written in the event cycle
        wr(12'h008, 32'd0);
        wr(12'h000, 32'h6);
        idle(2);
        wr(12'h000, 32'h6);
        rd(12'h000, 32'h7, "ovif_set_wins");
        wr(12'h000, 32'h0);

        // Collision: CNT write in a tick cycle
        wr(12'h00C, 32'h20);
        wr(12'h000, 32'h4);
        wr(12'h008, 32'h10);
        drive(1'b1, 1'b1, 1'b0, 12'h008, '0);
        #2 chk("cnt_wr_wins", prdata, 32'h10);
        drive(1'b1, 1'b1, 1'b0, 12'h008, '0);
        #2 chk("cnt_after_wr", prdata, 32'h11);
        wr(12'h000, 32'h0);

        // Ch1 down with prescale 4 (OVIE off)
        wr(12'h014, 32'd4);
        wr(12'h01C, 32'd5);
        wr(12'h018, 32'd2);
        wr(12'h010, 32'hC);
        for (int i = 0; i < 25; i++) begin
            drive(1'b1, 1'b1, 1'b0, 12'h018, '0);
            #2 chk("ch1_down_cnt", prdata, ch1_seq[i/5]);
        end
        rd(12'h010, 32'hD, "ch1_ovif");
        chk("ch1_irq_off", 32'(irq[1]), 32'd0);
        wr(12'h010, 32'h0);

        // Ch2 one-pulse: CNT 0,1,2,0 then holds
        wr(12'h024, 32'd0);
        wr(12'h02C, 32'd2);
        wr(12'h020, 32'h16);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, 12'h028, '0);
            #2 chk("ch2_opm_cnt", prdata, (i < 3) ? 32'(i) : 32'd0);
        end
        rd(12'h020, 32'h13, "ch2_opm_ctrl");
        chk("ch2_irq", 32'(irq[2]), 32'd1);
        wr(12'h020, 32'h0);

        // Unmapped access
        drive(1'b1, 1'b0, 1'b0, 12'h040, '0);
        drive(1'b1, 1'b1, 1'b0, 12'h040, '0);
        #2 chk("unmap_rd_err", 32'(pslverr), 32'd1);
        chk("unmap_rd_data", prdata, 32'd0);
        drive(1'b1, 1'b0, 1'b1, 12'h040, 32'hFFFF_FFFF);
        drive(1'b1, 1'b1, 1'b1, 12'h040, 32'hFFFF_FFFF);
        #2 chk("unmap_wr_err", 32'(pslverr), 32'd1);
        rd(12'h000, 32'h0, "unmap_no_alias");
        wr(12'h03C, 32'h0000_ABCD);
        rd(12'h03C, 32'h0000_ABCD, "last_mapped");
        chk("last_mapped_err", 32'(pslverr), 32'd0);

        // Randomised traffic
        for (int t = 0; t < 600; t++) begin
            logic [ADDR_W-1:0] a;
            logic [31:0]       d;
            int                r;
            r = int'($urandom_range(0, 3));
            a = ADDR_W'($urandom_range(0, CH_NUM - 1) * 16 + r * 4 + $urandom_range(0, 3));
            case (r)
                0:       d = $urandom_range(0, 31);
                1:       d = ($urandom_range(0, 19) == 0) ? $urandom : $urandom_range(0, 3);
                2:       d = $urandom_range(0, 9);
                default: d = $urandom_range(0, 7);
            endcase
            if ($urandom_range(0, 19) == 0) a = ADDR_W'($urandom_range(CH_NUM * 16, 4095));
            if ($urandom_range(0, 1) == 0) begin
                drive(1'b1, 1'b0, 1'b1, a, d);
                drive(1'b1, 1'b1, 1'b1, a, d);
            end else begin
                drive(1'b1, 1'b0, 1'b0, a, '0);
                drive(1'b1, 1'b1, 1'b0, a, '0);
            end
            idle(int'($urandom_range(0, 3)));
        end

        // Reset in the middle of counting
        wr(12'h004, 32'd0);
        wr(12'h00C, 32'd2);
        wr(12'h000, 32'h6);
        idle(8);
        @(negedge clk);
        #3 rst = 1'b1;
        #1 chk("mid_rst_irq", 32'(irq), 32'd0);
        chk("mid_rst_pready", 32'(pready), 32'd1);
        for (int w = 0; w < CH_NUM * 4; w++) begin
            drive(1'b1, 1'b1, 1'b0, ADDR_W'(w * 4), '0);
            #2 chk("mid_rst_read", prdata, 32'd0);
            chk("mid_rst_err", 32'(pslverr), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        psel = 0; penable = 0;
        idle(5);
        rd(12'h008, 32'd0, "post_rst_cnt");
        rd(12'h000, 32'd0, "post_rst_ctrl");
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
